// File: rtl/aes_output_interface.sv
// ---------------------------------------------------------------------------
// aes_output_interface
//
// Output stage that sits behind aes_engine. When the engine raises
// engine_done, the full ciphertext block is captured into a shift register.
// The block is then streamed out one byte per dout_valid/dout_ready
// handshake, most-significant byte first. After the last byte the engine is
// acknowledged with output_read. output_read stays high until engine_done is
// seen low, which completes a four-phase handshake.
//
// Parameters
//   BLOCK_BYTES  bytes per block (default 16)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_         in   asynchronous active-low reset
//   ct_in        in   ciphertext block, valid while engine_done is high
//   engine_done  in   engine has a block ready (level)
//   output_read  out  block fully delivered; held until engine_done drops
//   dout         out  current byte, 8'h00 when dout_valid is low
//   dout_valid   out  dout carries a valid byte
//   dout_ready   in   consumer accepts dout this cycle
//   busy         out  any state other than IDLE
//   byte_idx     out  index of the byte on dout (0 = MSB)
//   blocks_sent  out  fully delivered block count, wraps at 16 bits
// ---------------------------------------------------------------------------
module aes_output_interface #(
    parameter int  BLOCK_BYTES = 16,
    localparam int IDXW        = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1,
    localparam int CTW         = 8 * BLOCK_BYTES
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [CTW-1:0]  ct_in,
    input  logic            engine_done,
    output logic            output_read,
    output logic [7:0]      dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            busy,
    output logic [IDXW-1:0] byte_idx,
    output logic [15:0]     blocks_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BLOCK_BYTES - 1);

    state_t          state_q, state_d;
    logic [CTW-1:0]  shreg_q, shreg_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [15:0]     blocks_sent_q, blocks_sent_d;

    logic            handshake;

    assign handshake = (state_q == SEND) && dout_ready;

    // State and datapath registers. Reset clears everything, so a block
    // interrupted mid-stream is simply forgotten.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            idx_q         <= '0;
            blocks_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            idx_q         <= idx_d;
            blocks_sent_q <= blocks_sent_d;
        end
    end

    // Next-state logic. The block is captured only on leaving IDLE, so later
    // changes on ct_in cannot leak into a block being streamed. ACK waits
    // for engine_done to drop so the same block is never captured twice.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        idx_d         = idx_q;
        blocks_sent_d = blocks_sent_q;

        unique case (state_q)
            IDLE: begin
                if (engine_done) begin
                    shreg_d = ct_in;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    shreg_d = shreg_q << 8;
                    if (idx_q == LAST_IDX) begin
                        idx_d         = '0;
                        blocks_sent_d = blocks_sent_q + 16'd1;
                        state_d       = ACK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ACK: begin
                if (!engine_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registers only, so neither dout_ready nor
    // engine_done has a combinational path to any output.
    always_comb begin
        dout_valid  = (state_q == SEND);
        output_read = (state_q == ACK);
        busy        = (state_q != IDLE);
        dout        = dout_valid ? shreg_q[CTW-1 -: 8] : 8'h00;
        byte_idx    = idx_q;
        blocks_sent = blocks_sent_q;
    end

endmodule

// File: tb/tb_aes_output_interface.sv
// ---------------------------------------------------------------------------
// tb_aes_output_interface
//
// Directed bench for aes_output_interface with BLOCK_BYTES = 16. A
// behavioural model holds the captured block as a byte array plus a
// position and a phase, and every cycle the DUT outputs are compared against
// it. Hand-computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_aes_output_interface;

    localparam int BB = 16;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic [127:0] ct_in = '0;
    logic         engine_done = 1'b0;
    logic         dout_ready = 1'b0;
    logic         output_read;
    logic [7:0]   dout;
    logic         dout_valid;
    logic         busy;
    logic [3:0]   byte_idx;
    logic [15:0]  blocks_sent;

    int checks = 0;
    int errors = 0;

    aes_output_interface #(.BLOCK_BYTES(BB)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .ct_in       (ct_in),
        .engine_done (engine_done),
        .output_read (output_read),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .busy        (busy),
        .byte_idx    (byte_idx),
        .blocks_sent (blocks_sent)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Drive all data inputs at once.
    task automatic applyStimulus(input logic [127:0] ct, input logic done, input logic rdy);
        ct_in       = ct;
        engine_done = done;
        dout_ready  = rdy;
    endtask

    // Single literal comparison with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Behavioural model: phase 0 waiting for a block, 1 streaming bytes,
    // 2 waiting for the engine to drop done. mOffset lets the main sequence
    // preload the delivered-block count without a second writer of mCount.
    int       mPhase  = 0;
    int       mIdx    = 0;
    int       mCount  = 0;
    int       mOffset = 0;
    logic [7:0] mBytes [BB];

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mPhase = 0;
            mIdx   = 0;
            mCount = 0;
            for (int k = 0; k < BB; k++) mBytes[k] = 8'h00;
        end else begin
            case (mPhase)
                0: if (engine_done) begin
                    for (int k = 0; k < BB; k++) mBytes[k] = ct_in[8*(BB-k)-1 -: 8];
                    mIdx   = 0;
                    mPhase = 1;
                end
                1: if (dout_ready) begin
                    if (mIdx == BB - 1) begin
                        mCount = mCount + 1;
                        mPhase = 2;
                    end
                    mIdx = (mIdx + 1) % BB;
                end
                default: if (!engine_done) mPhase = 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    logic cmpOn = 1'b0;
    logic [7:0]  expDout;
    logic [15:0] expCount;
    logic        expValid, expRead, expBusy;
    logic [3:0]  expIdx;

    always @(negedge clk) begin
        if (cmpOn) begin
            expValid = (mPhase == 1);
            expRead  = (mPhase == 2);
            expBusy  = (mPhase != 0);
            expDout  = expValid ? mBytes[mIdx] : 8'h00;
            expIdx   = 4'(mIdx);
            expCount = 16'((mCount + mOffset) % 65536);
            checks++;
            if (dout !== expDout || dout_valid !== expValid || output_read !== expRead ||
                busy !== expBusy || byte_idx !== expIdx || blocks_sent !== expCount) begin
                errors++;
                $display("[TB] FAIL model t=%0t: got dout=%0h v=%0b rd=%0b busy=%0b idx=%0d cnt=%0h expected dout=%0h v=%0b rd=%0b busy=%0b idx=%0d cnt=%0h",
                         $time, dout, dout_valid, output_read, busy, byte_idx, blocks_sent,
                         expDout, expValid, expRead, expBusy, expIdx, expCount);
            end
        end
    end

    // Bytes actually accepted by the consumer, for sequence checks.
    logic       collectOn = 1'b0;
    logic [7:0] got [$];

    always @(posedge clk) begin
        if (collectOn && rst_ && dout_valid && dout_ready) got.push_back(dout);
    end

    // Bounded wait for output_read; an expired bound counts as a failure.
    task automatic waitForRead(input string name);
        int cyc;
        cyc = 0;
        while (output_read !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput(name, 32'(cyc < 100), 32'd1);
    endtask

    localparam logic [127:0] SEQ  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] DEAD = {8{16'hDEAD}};

    initial begin
        int cyc;

        // Reset with a block already waiting.
        applyStimulus(SEQ, 1'b1, 1'b1);
        #1 rst_ = 1'b0;
        #2;
        checkOutput("reset dout", 32'(dout), 32'h0);
        checkOutput("reset valid", 32'(dout_valid), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset read", 32'(output_read), 32'h0);
        checkOutput("reset count", 32'(blocks_sent), 32'h0);
        cmpOn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;

        // Block 1: ready held high, bytes 00..0F back to back.
        @(negedge clk);
        checkOutput("first valid", 32'(dout_valid), 32'h1);
        for (int k = 0; k < BB; k++) begin
            checkOutput("stream byte", 32'(dout), 32'(k));
            @(negedge clk);
        end
        checkOutput("ack read", 32'(output_read), 32'h1);
        checkOutput("ack valid", 32'(dout_valid), 32'h0);
        checkOutput("count after 1", 32'(blocks_sent), 32'h1);

        // Done held high in ACK: no re-capture.
        repeat (5) begin
            @(negedge clk);
            checkOutput("ack hold read", 32'(output_read), 32'h1);
            checkOutput("ack hold count", 32'(blocks_sent), 32'h1);
        end
        applyStimulus(SEQ, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("idle read", 32'(output_read), 32'h0);
        checkOutput("idle busy", 32'(busy), 32'h0);

        // Block 2: ready pattern 1,0,0,1.
        got.delete();
        collectOn = 1'b1;
        applyStimulus(SEQ, 1'b1, 1'b1);
        cyc = 0;
        while (output_read !== 1'b1 && cyc < 200) begin
            dout_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            cyc++;
        end
        checkOutput("toggle in time", 32'(cyc < 200), 32'd1);
        collectOn = 1'b0;
        checkOutput("toggle size", 32'(got.size()), 32'd16);
        for (int k = 0; k < got.size(); k++) checkOutput("toggle byte", 32'(got[k]), 32'(k));
        checkOutput("count after 2", 32'(blocks_sent), 32'h2);
        applyStimulus(SEQ, 1'b0, 1'b1);
        @(negedge clk);

        // Block 3: all FF, ct_in overwritten mid-stream.
        got.delete();
        collectOn = 1'b1;
        applyStimulus(ONES, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        ct_in = DEAD;
        waitForRead("ff block done");
        collectOn = 1'b0;
        checkOutput("ff size", 32'(got.size()), 32'd16);
        for (int k = 0; k < got.size(); k++) checkOutput("ff byte", 32'(got[k]), 32'hFF);
        checkOutput("count after 3", 32'(blocks_sent), 32'h3);
        applyStimulus(DEAD, 1'b0, 1'b1);
        @(negedge clk);

        // Block 4: reset while byte 5 is presented.
        applyStimulus(SEQ, 1'b1, 1'b1);
        cyc = 0;
        while (!(dout_valid === 1'b1 && byte_idx === 4'd5) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reach idx5", 32'(cyc < 50), 32'd1);
        checkOutput("idx5 byte", 32'(dout), 32'h05);
        #2 rst_ = 1'b0;
        #1;
        checkOutput("midrst dout", 32'(dout), 32'h0);
        checkOutput("midrst valid", 32'(dout_valid), 32'h0);
        checkOutput("midrst busy", 32'(busy), 32'h0);
        checkOutput("midrst idx", 32'(byte_idx), 32'h0);
        checkOutput("midrst count", 32'(blocks_sent), 32'h0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        checkOutput("restart valid", 32'(dout_valid), 32'h1);
        checkOutput("restart byte", 32'(dout), 32'h00);
        waitForRead("restart done");
        checkOutput("count after rst", 32'(blocks_sent), 32'h1);
        applyStimulus(SEQ, 1'b0, 1'b1);
        @(negedge clk);

        // Block 5: preload the count to FFFF and watch it wrap.
        #2;
        force dut.blocks_sent_q = 16'hFFFF;
        mOffset = 65535 - mCount;
        @(negedge clk);
        #2;
        release dut.blocks_sent_q;
        @(negedge clk);
        checkOutput("preload count", 32'(blocks_sent), 32'hFFFF);
        applyStimulus(SEQ, 1'b1, 1'b1);
        waitForRead("wrap block done");
        checkOutput("wrap count", 32'(blocks_sent), 32'h0);
        applyStimulus(SEQ, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        cmpOn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
